cordic_iter_core: RTL
=====================

# cordic_iter_core

Parametrised iterative CORDIC engine for the function generator's phase-to-amplitude and angle paths: one shared add/shift datapath, run for N_ITER cycles per sample. It supports rotation and vectoring modes selected per transaction, quadrant pre-rotation, guard bits with output saturation, and valid/ready handshakes on both sides. It supersedes the fixed 8-bit rotation-only iterative core and sits between the phase accumulator and the output DAC formatter.

## Interface
- WIDTH, 16: sample width, 8..24. X/Y are Q1.(WIDTH-1); Z is angle/π in Q1.(WIDTH-1), so +0.5 = +π/2.
- N_ITER, WIDTH: micro-rotations per sample, 4..WIDTH.
- GUARD, 2: extra MSBs on internal X/Y.
- clk_i  in  1  clock; all registers on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  input sample valid.
- in_ready_o  out  1  core accepts a sample (registered).
- mode_i  in  1  0 = rotation (drive Z→0), 1 = vectoring (drive Y→0); sampled on accept.
- X_i, Y_i, Z_i  in  WIDTH each, signed  input vector and angle.
- out_valid_o  out  1  result valid, held until taken.
- out_ready_i  in  1  downstream accepts the result.
- X_o, Y_o, Z_o  out  WIDTH each, signed  result, stable while out_valid_o=1.

## Operation
- FSM states: IDLE, ROC, ITER, DONE. Accept occurs when in_valid_i & in_ready_o. On accept, capture X/Y sign-extended to WIDTH+GUARD, plus Z and mode, then go to ROC.
- ROC (1 cycle), PI_HALF = 2^(WIDTH-2):
  - Rotation mode:
    - Z > PI_HALF: (X,Y,Z) ← (−Y, X, Z−PI_HALF).
    - Z < −PI_HALF: (X,Y,Z) ← (Y, −X, Z+PI_HALF).
    - Otherwise pass through.
  - Vectoring mode, only when X < 0:
    - Y ≥ 0: (X,Y,Z) ← (Y, −X, Z+PI_HALF).
    - Y < 0: (X,Y,Z) ← (−Y, X, Z−PI_HALF).
  - Then i←0 and go to ITER.
- ITER, iteration i = 0..N_ITER−1, one per cycle:
  - Direction d=+1 when (rotation: Z ≥ 0) or (vectoring: Y < 0); otherwise d=−1.
  - X ← X − d·(Y>>>i); Y ← Y + d·(X>>>i); Z ← Z − d·atan_i. All updates use old values.
  - Shifts are arithmetic.
  - Z arithmetic is modulo 2^WIDTH; wrap-around at ±π is intended.
  - After i = N_ITER−1, go to DONE.
- atan_i table:
  - Internal 24-entry constant table of round(atan(2^-i)/π·2^31), 32-bit.
  - atan_i = that entry rounded to WIDTH bits (add 2^(31−WIDTH), then >> (32−WIDTH)).
  - Entries past N_ITER are unused.
- Output formatting:
  - X_o/Y_o saturate from WIDTH+GUARD to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; Z_o is Z directly.
  - No gain compensation: magnitude is scaled by K≈1.6468.
- DONE: out_valid_o=1 and outputs frozen. When out_ready_i=1, go to IDLE.
- in_ready_o:
  - 1 only in IDLE.
  - Deasserts the cycle after accept; reasserts the cycle after the output transfer.
  - in_valid_i outside IDLE is ignored; no queueing.
- Reset, including mid-operation: aborts the sample immediately. All registers clear, state IDLE, in_ready_o=0, out_valid_o=0, X_o=Y_o=Z_o=0. in_ready_o rises on the first clock edge after rstn_i deasserts.

## Timing
- Accept at edge 0: ROC at edge 1, iterations at edges 2..N_ITER+1.
- out_valid_o=1 from edge N_ITER+1. Latency is N_ITER+1 cycles from accept to result valid.
- Output transfer at edge T (out_valid_o & out_ready_i): in_ready_o=1 from edge T+1. Next accept no earlier than edge T+1.
- Minimum sample period: N_ITER+3 cycles.
- out_valid_o held indefinitely under backpressure. Outputs do not change while held.
- in_valid_i high throughout, with out_ready_i tied high: back-to-back samples every N_ITER+3 cycles, none dropped.

## Test plan
- Rotation, WIDTH=16: X=0x2000, Y=0, Z=0 → X_o≈0x34B3, Y_o≈0, Z_o≈0. Tolerance ±N_ITER LSB on all checks unless stated.
- Rotation with ROC: X=0x4000, Y=0, Z=0x6000 (135°) → X_o≈0xB578, Y_o≈0x4A88, Z_o≈0.
- Vectoring with ROC:
  - X=0x2000, Y=0x2000 → Z_o≈0x2000 (π/4), X_o≈0x4A88, Y_o≈0.
  - X=−0x2000, Y=0x2000 → Z_o≈0x6000.
- Saturation: rotation X=0x7FFF, Y=0, Z=0 → X_o=0x7FFF exactly, no wrap.
- Handshake:
  - Hold out_ready_i=0 for 20 cycles after out_valid_o → outputs and out_valid_o stable, in_ready_o=0.
  - Release → in_ready_o=1 the next cycle.
  - Verify latency equals N_ITER+1 cycles.
- Reset mid-ITER: assert rstn_i=0 asynchronously → all outputs 0 without a clock edge. After release, in_ready_o=1 one edge later and a fresh sample completes correctly.

Source files
------------

// File: rtl/cordic_iter_core.sv
// Iterative CORDIC engine: one shared shift/add datapath stepped N_ITER times per sample,
// rotation or vectoring per transaction, quadrant pre-rotation and saturated X/Y outputs.
module cordic_iter_core #(
  parameter int WIDTH  = 16,
  parameter int N_ITER = WIDTH,
  parameter int GUARD  = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] X_i,
  input  logic [WIDTH-1:0] Y_i,
  input  logic [WIDTH-1:0] Z_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] X_o,
  output logic [WIDTH-1:0] Y_o,
  output logic [WIDTH-1:0] Z_o,
  output logic [1:0]       state_o
);

  // Handshakes: a sample moves on a rising edge where valid & ready are both 1.
  // Input side: in_ready_o is registered and high only in IDLE. Output side:
  // out_valid_o is high in DONE and X_o/Y_o/Z_o stay frozen until out_ready_i.

  localparam int IW = WIDTH + GUARD;
  localparam logic signed [WIDTH-1:0] PI_HALF  = WIDTH'(2 ** (WIDTH - 2));
  localparam logic [31:0]             ATAN_RND = 32'(1) << (31 - WIDTH);
  localparam logic [4:0]              LAST_IT  = 5'(N_ITER - 1);

  typedef enum logic [1:0] {IDLE, ROC, ITER, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [IW-1:0]    x_q, x_d, y_q, y_d;
  logic signed [WIDTH-1:0] z_q, z_d;
  logic                    mode_q, mode_d;
  logic [4:0]              iter_q, iter_d;
  logic                    in_ready_q;

  logic                    accept;
  logic                    d_pos;
  logic signed [IW-1:0]    x_sh, y_sh;
  logic signed [WIDTH-1:0] atan_w;

  // round(atan(2^-i)/pi * 2^31)
  function automatic logic [31:0] atan_entry(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_entry = 32'h2000_0000;
      5'd1:    atan_entry = 32'h12E4_051E;
      5'd2:    atan_entry = 32'h09FB_385B;
      5'd3:    atan_entry = 32'h0511_11D4;
      5'd4:    atan_entry = 32'h028B_0D43;
      5'd5:    atan_entry = 32'h0145_D7E1;
      5'd6:    atan_entry = 32'h00A2_F61E;
      5'd7:    atan_entry = 32'h0051_7C55;
      5'd8:    atan_entry = 32'h0028_BE53;
      5'd9:    atan_entry = 32'h0014_5F2F;
      5'd10:   atan_entry = 32'h000A_2F98;
      5'd11:   atan_entry = 32'h0005_17CC;
      5'd12:   atan_entry = 32'h0002_8BE6;
      5'd13:   atan_entry = 32'h0001_45F3;
      5'd14:   atan_entry = 32'h0000_A2FA;
      5'd15:   atan_entry = 32'h0000_517D;
      5'd16:   atan_entry = 32'h0000_28BE;
      5'd17:   atan_entry = 32'h0000_145F;
      5'd18:   atan_entry = 32'h0000_0A30;
      5'd19:   atan_entry = 32'h0000_0518;
      5'd20:   atan_entry = 32'h0000_028C;
      5'd21:   atan_entry = 32'h0000_0146;
      5'd22:   atan_entry = 32'h0000_00A3;
      5'd23:   atan_entry = 32'h0000_0051;
      default: atan_entry = 32'h0000_0000;
    endcase
  endfunction

  // Overflow when the guard bits and the output sign bit disagree.
  function automatic logic [WIDTH-1:0] sat(input logic signed [IW-1:0] v);
    if (!v[IW-1] && (|v[IW-2:WIDTH-1]))
      sat = {1'b0, {(WIDTH-1){1'b1}}};
    else if (v[IW-1] && !(&v[IW-2:WIDTH-1]))
      sat = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sat = v[WIDTH-1:0];
  endfunction

  assign accept = (state_q == IDLE) && in_valid_i && in_ready_q;
  assign d_pos  = mode_q ? y_q[IW-1] : ~z_q[WIDTH-1];
  assign x_sh   = x_q >>> iter_q;
  assign y_sh   = y_q >>> iter_q;
  assign atan_w = WIDTH'((atan_entry(iter_q) + ATAN_RND) >> (32 - WIDTH));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    mode_d  = mode_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d     = {{GUARD{X_i[WIDTH-1]}}, X_i};
          y_d     = {{GUARD{Y_i[WIDTH-1]}}, Y_i};
          z_d     = Z_i;
          mode_d  = mode_i;
          state_d = ROC;
        end
      end
      ROC: begin
        // Bring the vector into the right half-plane so the micro-rotations converge.
        if (!mode_q) begin
          if (z_q > PI_HALF) begin
            x_d = -y_q;
            y_d = x_q;
            z_d = z_q - PI_HALF;
          end else if (z_q < -PI_HALF) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = z_q + PI_HALF;
          end
        end else if (x_q[IW-1]) begin
          if (!y_q[IW-1]) begin
            x_d = y_q;
            y_d = -x_q;
            z_d = z_q + PI_HALF;
          end else begin
            x_d = -y_q;
            y_d = x_q;
            z_d = z_q - PI_HALF;
          end
        end
        iter_d  = 5'd0;
        state_d = ITER;
      end
      ITER: begin
        if (d_pos) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_w;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_w;
        end
        if (iter_q == LAST_IT) state_d = DONE;
        else                   iter_d  = iter_q + 5'd1;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      mode_q     <= 1'b0;
      iter_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      mode_q     <= mode_d;
      iter_q     <= iter_d;
      in_ready_q <= (state_d == IDLE);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (state_q == DONE);
  assign X_o         = sat(x_q);
  assign Y_o         = sat(y_q);
  assign Z_o         = z_q;
  assign state_o     = state_q;

endmodule
